// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl: EX-stage operand forwarding selects and load-use stall for a 3-slot in-flight tracker.
// Define FWD_STATS_EN to add saturating stall_cnt / fwd_cnt event counters.
module fwd_sel_ctrl #(
  parameter int REG_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              stall
`ifdef FWD_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fwd_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              is_load;
  } slot_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;
  localparam logic [1:0] SEL_RET = 2'b11;

  slot_t      ex_r;
  slot_t      mem_r;
  slot_t      wb_r;
  slot_t      id_slot_s;
  logic       stall_s;
  logic       issue_s;
  logic [1:0] sel_a_s;
  logic [1:0] sel_b_s;

  // r0 is hardwired zero, so a write to it never produces a forwardable value.
  function automatic logic is_producer(input slot_t s, input logic [REG_AW-1:0] r);
    return s.valid && s.wen && (s.rd == r) && (r != {REG_AW{1'b0}});
  endfunction

  // Selects are named for where the producer will sit once the consumer reaches EX.
  function automatic logic [1:0] pick_sel(input slot_t ex, input slot_t mem, input slot_t wb,
                                          input logic [REG_AW-1:0] r);
    logic [1:0] sel;
    if (is_producer(ex, r)) begin
      sel = SEL_MEM;
    end else if (is_producer(mem, r)) begin
      sel = SEL_WB;
    end else if (is_producer(wb, r)) begin
      sel = SEL_RET;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Hazard detection and issue-time select computation against pre-edge slots.
  always_comb begin
    stall_s   = id_valid && !flush && ex_r.is_load &&
                (is_producer(ex_r, id_rs) || is_producer(ex_r, id_rt));
    issue_s   = id_valid && !stall_s && !flush;
    id_slot_s = '{valid: 1'b1, rd: id_rd, wen: id_wen, is_load: id_is_load};
    if (issue_s) begin
      sel_a_s = pick_sel(ex_r, mem_r, wb_r, id_rs);
      sel_b_s = pick_sel(ex_r, mem_r, wb_r, id_rt);
    end else begin
      sel_a_s = SEL_RF;
      sel_b_s = SEL_RF;
    end
  end

  assign stall = stall_s;

  // Tracker shift and select registers; stall or flush turns the EX entry into a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_r      <= '0;
      mem_r     <= '0;
      wb_r      <= '0;
      fwd_sel_a <= SEL_RF;
      fwd_sel_b <= SEL_RF;
    end else begin
      wb_r      <= mem_r;
      mem_r     <= ex_r;
      ex_r      <= issue_s ? id_slot_s : '0;
      fwd_sel_a <= sel_a_s;
      fwd_sel_b <= sel_b_s;
    end
  end

`ifdef FWD_STATS_EN
  // Saturating event counters; a dual-operand forward counts once per issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= 16'h0000;
      fwd_cnt   <= 16'h0000;
    end else begin
      if (stall_s && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (issue_s && ((sel_a_s != SEL_RF) || (sel_b_s != SEL_RF)) && (fwd_cnt != 16'hFFFF)) begin
        fwd_cnt <= fwd_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
